avmm_mailbox_slave: RTL
=======================

// Module: avmm_mailbox_slave
// PURPOSE
//  Avalon-MM burst slave that terminates the JTAG bridge master bus (address/read/write/burstcount/
//  waitrequest/readdatavalid) in a 32-bit word-addressed mailbox RAM shared with SAM D21 firmware.
//  A write to the doorbell word raises an interrupt line routed to oSAM_INT in the top level.
//  Sits between the JTAG master and the SAM interrupt pin in the wMEM_CLK domain.
// PARAMETERS
//  ADDR_W         8    word-address width; mailbox depth = 2**ADDR_W words
//  BURST_W        5    burstcount width; matches the JTAG master burstcount port
//  DOORBELL_ADDR  255  word address of the doorbell register (inside the RAM range)
// PORTS
//  iCLK            in   1        single clock for all logic
//  iRESET          in   1        synchronous, active-high reset
//  iADDRESS        in   ADDR_W   word address, sampled on accepted command beat
//  iREAD           in   1        read command
//  iWRITE          in   1        write command / write beat
//  iWRITE_DATA     in   32       write data
//  iBYTE_ENABLE    in   4        per-byte write enable
//  iBURST_COUNT    in   BURST_W  beats in burst, sampled on first beat
//  oWAIT_REQUEST   out  1        1 = command/beat not accepted this cycle
//  oREAD_DATA      out  32       read data
//  oREAD_DATAVALID out  1        1 = oREAD_DATA valid this cycle
//  oINT            out  1        doorbell interrupt, level, to SAM
//  iINT_ACK        in   1        1-cycle pulse from SAM side clears oINT
// BEHAVIOUR
//  Reset: state IDLE, oWAIT_REQUEST=0, oREAD_DATAVALID=0, oREAD_DATA=0, oINT=0, counters=0.
//   RAM contents not cleared. Reset mid-burst aborts: remaining beats dropped, no datavalid.
//  States: IDLE, WR_BURST, RD_BURST.
//  IDLE: oWAIT_REQUEST=0. iWRITE -> write beat 0 to iADDRESS, latch addr+1 and count-1;
//   count-1>0 -> WR_BURST else stay. iREAD (iWRITE=0) -> latch addr/count, -> RD_BURST.
//   iREAD and iWRITE both high: write wins, read ignored.
//  WR_BURST: oWAIT_REQUEST=0; each cycle with iWRITE=1 writes one beat at running address,
//   address+1, count-1; iWRITE=0 inserts a gap (no write). Last beat -> IDLE.
//  RD_BURST: oWAIT_REQUEST=1 (no new commands); one RAM read issued per cycle, no gaps.
//   RAM read latency 1 -> oREAD_DATAVALID high for exactly N consecutive cycles,
//   first valid 2 cycles after the accepting cycle. Return to IDLE after the final beat
//   is issued; oWAIT_REQUEST drops the cycle after, so next command overlaps last datavalid.
//  Burstcount 0 treated as 1. Address arithmetic modulo 2**ADDR_W (wraps 255->0).
//  Byte enables honoured per byte; bytes with enable 0 keep old value.
//  Doorbell: any accepted write beat at DOORBELL_ADDR with iBYTE_ENABLE[0]=1 sets oINT the
//   next cycle; data also stored in RAM. iINT_ACK clears oINT. Set and ack same cycle: set wins.
//  Read of DOORBELL_ADDR returns stored word; does not affect oINT.
// CONFIGURATION
//  MBOX_BURST_EN defined: behaviour above. Undefined: iBURST_COUNT ignored, every command is
//   single beat, WR_BURST unreachable, RD_BURST lasts 1 cycle (one datavalid per read).
// TESTING
//  1 Reset then single write 0xDEADBEEF @0x10 BE=F, read @0x10 -> datavalid 2 cyc later, 0xDEADBEEF.
//  2 Write burst 4 beats @0xFE (data 1..4) -> RAM[FE]=1,[FF]=2,[00]=3,[01]=4; oINT set (beat @FF).
//  3 Read burst 8 @0x00 -> waitrequest high during issue, 8 back-to-back datavalids, no gaps.
//  4 Write 0x000000AA @0x20 BE=0001 over 0x11223344 -> readback 0x112233AA.
//  5 Doorbell write with iINT_ACK same cycle as set -> oINT=1; later ack -> oINT=0.
//  6 Assert iRESET mid read burst beat 3 of 8 -> datavalid low next cycle, IDLE, waitrequest=0.

Source files
------------

// File: rtl/avmm_mailbox_slave.sv
// Avalon-MM burst slave terminating the JTAG bridge master in a 32-bit
// word-addressed mailbox RAM shared with the SAM D21 firmware. A write to the
// doorbell word raises a level interrupt that the SAM side clears with a pulse.
// Optional feature macro: MBOX_BURST_EN (multi-beat bursts). When it is not
// defined, every command is a single beat and iBURST_COUNT is ignored.
module avmm_mailbox_slave #(
    parameter int ADDR_W        = 8,
    parameter int BURST_W       = 5,
    parameter int DOORBELL_ADDR = 255
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic [ADDR_W-1:0]  iADDRESS,
    input  logic               iREAD,
    input  logic               iWRITE,
    input  logic [31:0]        iWRITE_DATA,
    input  logic [3:0]         iBYTE_ENABLE,
    input  logic [BURST_W-1:0] iBURST_COUNT,
    output logic               oWAIT_REQUEST,
    output logic [31:0]        oREAD_DATA,
    output logic               oREAD_DATAVALID,
    output logic               oINT,
    input  logic               iINT_ACK
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DOORBELL = ADDR_W'(DOORBELL_ADDR);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [BURST_W-1:0] count_reg, count_next;
    logic               doorbell_int_reg, doorbell_int_next;
    logic               rd_valid_reg;
    logic [BURST_W-1:0] cmd_count;
    logic               wr_en;
    logic               rd_en;
    logic [ADDR_W-1:0]  wr_addr;

`ifdef MBOX_BURST_EN
    // A burstcount of zero is treated as a single beat.
    assign cmd_count = (iBURST_COUNT == '0) ? BURST_W'(1) : iBURST_COUNT;
`else
    logic unused_burst_count;
    assign unused_burst_count = ^iBURST_COUNT;
    assign cmd_count = BURST_W'(1);
`endif

    // Command decode, burst sequencing and RAM port control.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_addr    = addr_reg;
        rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (iWRITE) begin
                    // Write wins over a simultaneous read; beat 0 goes straight in.
                    wr_en      = ~iRESET;
                    wr_addr    = iADDRESS;
                    addr_next  = iADDRESS + ADDR_W'(1);
                    count_next = cmd_count - BURST_W'(1);
                    if (cmd_count != BURST_W'(1)) state_next = WR_BURST;
                end else if (iREAD) begin
                    addr_next  = iADDRESS;
                    count_next = cmd_count;
                    state_next = RD_BURST;
                end
            end
            WR_BURST: begin
                // iWRITE low is a gap: nothing is written and nothing advances.
                if (iWRITE) begin
                    wr_en      = ~iRESET;
                    addr_next  = addr_reg + ADDR_W'(1);
                    count_next = count_reg - BURST_W'(1);
                    if (count_reg == BURST_W'(1)) state_next = IDLE;
                end
            end
            RD_BURST: begin
                // One RAM read per cycle, no gaps; leave as soon as the last is issued.
                rd_en      = 1'b1;
                addr_next  = addr_reg + ADDR_W'(1);
                count_next = count_reg - BURST_W'(1);
                if (count_reg == BURST_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A doorbell set beats an acknowledge arriving in the same cycle.
        if (wr_en && (wr_addr == DOORBELL) && iBYTE_ENABLE[0]) doorbell_int_next = 1'b1;
        else if (iINT_ACK)                                     doorbell_int_next = 1'b0;
        else                                                   doorbell_int_next = doorbell_int_reg;
    end

    // Control state registers; reset also aborts any burst in flight.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            count_reg        <= '0;
            doorbell_int_reg <= 1'b0;
            rd_valid_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            count_reg        <= count_next;
            doorbell_int_reg <= doorbell_int_next;
            rd_valid_reg     <= rd_en;
        end
    end

    // Mailbox RAM split into byte lanes so each byte enable maps to its own write port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_lane_reg;

            // Byte-lane write; contents survive reset.
            always_ff @(posedge iCLK) begin
                if (wr_en && iBYTE_ENABLE[gi]) mem[wr_addr] <= iWRITE_DATA[gi*8 +: 8];
            end

            // Registered read port, one cycle of latency behind the issue cycle.
            always_ff @(posedge iCLK) begin
                if (iRESET)     rd_lane_reg <= '0;
                else if (rd_en) rd_lane_reg <= mem[addr_reg];
            end

            assign oREAD_DATA[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

    assign oWAIT_REQUEST   = (state_reg == RD_BURST);
    assign oREAD_DATAVALID = rd_valid_reg;
    assign oINT            = doorbell_int_reg;

endmodule
